seizure_detector: RTL and testbench
===================================

# seizure_detector

Consumes the feature stream from `ps_module` (`dout` / `data_valid`) and turns it into a per-sample seizure decision. The decision uses dual-threshold hysteresis with consecutive-sample qualification and a post-event holdoff. It sits directly downstream of the feature datapath and produces the `seizure` tag compared against the ground-truth tag file in system benches. It also produces onset/offset pulses and a saturating event count for the host.

## Interface
- `FEAT_WIDTH`, 40, width of the signed feature word; matches `ps_module` `OUTPUT_WIDTH`.
- `CNT_WIDTH`, 16, width of the qualification/holdoff counters and their config inputs.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  global enable; when low, all state and outputs hold and `feat_valid` is ignored.
- `feat_in`  in  FEAT_WIDTH  signed feature; connects to `ps_module.dout`.
- `feat_valid`  in  1  feature qualifier; connects to `ps_module.data_valid`. Single-cycle strobes or back-to-back strobes are both legal.
- `thr_on`  in  FEAT_WIDTH  signed onset threshold.
- `thr_off`  in  FEAT_WIDTH  signed offset threshold.
- `on_count`  in  CNT_WIDTH  consecutive samples ≥ `thr_on` required for onset; 0 is treated as 1.
- `off_count`  in  CNT_WIDTH  consecutive samples < `thr_off` required for offset; 0 is treated as 1.
- `holdoff`  in  CNT_WIDTH  valid samples ignored after offset before re-arming.
- `seizure`  out  1  level; high while in SEIZURE.
- `onset`  out  1  one-cycle pulse on the SEIZURE entry cycle.
- `offset`  out  1  one-cycle pulse on the SEIZURE exit cycle.
- `event_count`  out  16  number of onsets since reset; saturates at 0xFFFF.
- `state`  out  2  current FSM state, for debug.

## Operation
- States and encodings: IDLE = 0, CAND = 1, SEIZURE = 2, HOLDOFF = 3. There is one internal run counter `run` (CNT_WIDTH bits, saturating).
- A state advances only on a cycle with `en & feat_valid`, called a "sample". Non-sample cycles hold all state.
- Comparisons are signed over the full FEAT_WIDTH: "above" means `feat_in >= thr_on`; "below" means `feat_in < thr_off`.
- IDLE:
  - sample above with effective `on_count` = 1: go to SEIZURE.
  - sample above otherwise: go to CAND with `run` = 1.
  - all other samples: stay, `run` = 0.
- CAND:
  - sample above with `run + 1 >= eff_on_count`: go to SEIZURE, `run` = 0.
  - sample above otherwise: `run++`.
  - sample not above: go to IDLE, `run` = 0.
- SEIZURE:
  - sample below with `run + 1 >= eff_off_count`: go to HOLDOFF, `run` = 0.
  - sample below otherwise: `run++`.
  - sample not below: `run` = 0 (streak broken).
- HOLDOFF:
  - `holdoff` = 0: go to IDLE on the next clock, regardless of sample.
  - otherwise each sample does `run++`; on `run + 1 >= holdoff`, go to IDLE with `run` = 0.
  - feature values are ignored in this state.
- Config inputs are sampled live on every sample. A change mid-streak applies to the next comparison; there is no restart.
- Comparison to the count thresholds uses `>=`, so lowering a count below the current `run` fires on the next qualifying sample.
- `event_count` increments on each SEIZURE entry and saturates at 0xFFFF.
- `thr_off > thr_on` is legal. Hysteresis is then inverted but behaviour still follows the rules above exactly.

## Timing
- All outputs are registered.
- Reset values: `seizure` = 0, `onset` = 0, `offset` = 0, `event_count` = 0, `state` = IDLE (0), `run` = 0.
- `rst` has priority over `en`. Asserting `rst` mid-event drops `seizure` on the next edge without producing an `offset` pulse.
- Latency: a sample at edge N that causes a transition shows the new `state`/`seizure` and the `onset`/`offset` pulse after edge N. That means visible in cycle N+1, low again in N+2 unless a new event fires.
- `en` low on the edge where a transition would occur: no transition, and any pending pulse is not generated. Pulses are never stretched; they deassert after one cycle even if `en` falls.
- `feat_valid` high with `en` low is discarded; it is not queued.

## Test plan
- Reset check: hold `rst` = 1 for 3 cycles with `feat_valid` toggling → all outputs 0 and `state` = 0 throughout and after release.
- Onset qualification: `thr_on` = 100, `on_count` = 3, feed 150, 150, 50, 150, 150, 150 (back-to-back valid) → `state` 1, 1, 0, 1, 1, 2. `onset` pulses once, on the cycle after the sixth sample; `event_count` = 1.
- Offset + holdoff: from SEIZURE with `thr_off` = 80, `off_count` = 2, `holdoff` = 2, feed 70, 90, 70, 70, 500, 500 → SEIZURE persists through the streak break at 90. `offset` pulses after the 4th sample; the two 500s are ignored in HOLDOFF; `state` = 0 after the 6th sample.
- Gated valid and enable: CAND with `run` = 1 and `on_count` = 3; feed above samples with gaps of 4 idle cycles, plus one above sample while `en` = 0 → that sample is not counted. Onset occurs only on the third counted sample.
- Edge configs: `on_count` = 0, `off_count` = 0, `holdoff` = 0, threshold = −5, feature = −5 → onset on the first sample. A below sample gives offset, then IDLE one clock later. Negative-equal compares count as above.
- Saturation / reset mid-event: force 65 540 onset/offset cycles → `event_count` holds at 0xFFFF. Assert `rst` while `seizure` = 1 → `seizure` = 0 next cycle with no `offset` pulse.

Source files
------------

// File: rtl/seizure_detector.sv
// Per-sample seizure decision from the feature stream: dual-threshold hysteresis,
// consecutive-sample qualification, post-event holdoff, onset/offset pulses and event count.
module seizure_detector #(
  parameter int unsigned FEAT_WIDTH = 40,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned EVT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic signed [FEAT_WIDTH-1:0] feat_in,
  input  logic                         feat_valid,
  input  logic signed [FEAT_WIDTH-1:0] thr_on,
  input  logic signed [FEAT_WIDTH-1:0] thr_off,
  input  logic [CNT_WIDTH-1:0]         on_count,
  input  logic [CNT_WIDTH-1:0]         off_count,
  input  logic [CNT_WIDTH-1:0]         holdoff,
  output logic                         seizure,
  output logic                         onset,
  output logic                         offset,
  output logic [EVT_WIDTH-1:0]         event_count,
  output logic [1:0]                   state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CAND = 2'd1;
  localparam logic [1:0] S_SEIZ = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]           state_nxt;
  logic [CNT_WIDTH-1:0] run, run_nxt, run_inc;
  logic [CNT_WIDTH:0]   run_p1, eff_on, eff_off, hold_ext;
  logic                 above, below;
  logic                 seizure_nxt, onset_nxt, offset_nxt;
  logic [EVT_WIDTH-1:0] event_count_nxt;

  // Count comparisons are done one bit wider so run + 1 never wraps.
  assign above    = feat_in >= thr_on;
  assign below    = feat_in < thr_off;
  assign run_p1   = {1'b0, run} + (CNT_WIDTH+1)'(1);
  assign run_inc  = (&run) ? run : run + CNT_WIDTH'(1);
  assign eff_on   = (on_count == '0) ? (CNT_WIDTH+1)'(1) : {1'b0, on_count};
  assign eff_off  = (off_count == '0) ? (CNT_WIDTH+1)'(1) : {1'b0, off_count};
  assign hold_ext = {1'b0, holdoff};

  // State and run counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      run   <= '0;
    end else begin
      state <= state_nxt;
      run   <= run_nxt;
    end
  end

  // Next-state logic; nothing moves without en, and only HOLDOFF with zero holdoff ignores feat_valid
  always_comb begin
    state_nxt = state;
    run_nxt   = run;
    if (en) begin
      case (state)
        S_IDLE: begin
          if (feat_valid) begin
            run_nxt = '0;
            if (above) begin
              if (eff_on == (CNT_WIDTH+1)'(1)) begin
                state_nxt = S_SEIZ;
              end else begin
                state_nxt = S_CAND;
                run_nxt   = CNT_WIDTH'(1);
              end
            end
          end
        end
        S_CAND: begin
          if (feat_valid) begin
            if (!above) begin
              state_nxt = S_IDLE;
              run_nxt   = '0;
            end else if (run_p1 >= eff_on) begin
              state_nxt = S_SEIZ;
              run_nxt   = '0;
            end else begin
              run_nxt = run_inc;
            end
          end
        end
        S_SEIZ: begin
          if (feat_valid) begin
            if (!below) begin
              run_nxt = '0;
            end else if (run_p1 >= eff_off) begin
              state_nxt = S_HOLD;
              run_nxt   = '0;
            end else begin
              run_nxt = run_inc;
            end
          end
        end
        default: begin
          if (holdoff == '0) begin
            state_nxt = S_IDLE;
            run_nxt   = '0;
          end else if (feat_valid) begin
            if (run_p1 >= hold_ext) begin
              state_nxt = S_IDLE;
              run_nxt   = '0;
            end else begin
              run_nxt = run_inc;
            end
          end
        end
      endcase
    end
  end

  // Output decode from the pending transition; pulses self-clear because they are recomputed every cycle
  always_comb begin
    seizure_nxt     = (state_nxt == S_SEIZ);
    onset_nxt       = (state != S_SEIZ) && (state_nxt == S_SEIZ);
    offset_nxt      = (state == S_SEIZ) && (state_nxt == S_HOLD);
    event_count_nxt = event_count;
    if (onset_nxt && !(&event_count)) begin
      event_count_nxt = event_count + EVT_WIDTH'(1);
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      seizure     <= 1'b0;
      onset       <= 1'b0;
      offset      <= 1'b0;
      event_count <= '0;
    end else begin
      seizure     <= seizure_nxt;
      onset       <= onset_nxt;
      offset      <= offset_nxt;
      event_count <= event_count_nxt;
    end
  end

endmodule

// File: tb/tb_seizure_detector.sv
// Self-checking bench for seizure_detector: directed scenarios with literal expectations
// plus randomized traffic, all checked every cycle against a rule-level reference model.
module tb_seizure_detector;

  logic               clk = 1'b0;
  logic               rst, en, feat_valid;
  logic signed [39:0] feat_in, thr_on, thr_off;
  logic [15:0]        on_count, off_count, holdoff;
  logic               seizure, onset, offset;
  logic [15:0]        event_count;
  logic [1:0]         state;
  logic               seizure_s, onset_s, offset_s;
  logic [3:0]         event_count_s;
  logic [1:0]         state_s;

  int  n_vec = 0;
  int  n_err = 0;
  bit  armed = 0;

  // Reference model: phase 0 idle, 1 qualifying, 2 in seizure, 3 holdoff
  int  m_phase = 0;
  int  m_streak = 0;
  int  m_events = 0;
  bit  m_on = 0;
  bit  m_off = 0;

  always #5 clk = ~clk;

  seizure_detector dut (
    .clk(clk), .rst(rst), .en(en), .feat_in(feat_in), .feat_valid(feat_valid),
    .thr_on(thr_on), .thr_off(thr_off), .on_count(on_count), .off_count(off_count),
    .holdoff(holdoff), .seizure(seizure), .onset(onset), .offset(offset),
    .event_count(event_count), .state(state)
  );

  // Narrow event counter instance so saturation is reachable in a short run
  seizure_detector #(.EVT_WIDTH(4)) dut_s (
    .clk(clk), .rst(rst), .en(en), .feat_in(feat_in), .feat_valid(feat_valid),
    .thr_on(thr_on), .thr_off(thr_off), .on_count(on_count), .off_count(off_count),
    .holdoff(holdoff), .seizure(seizure_s), .onset(onset_s), .offset(offset_s),
    .event_count(event_count_s), .state(state_s)
  );

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    int  need_on, need_off, hold;
    bit  is_above, is_below;
    m_on  = 0;
    m_off = 0;
    if (rst) begin
      m_phase = 0; m_streak = 0; m_events = 0;
      return;
    end
    if (!en) return;
    need_on  = (on_count == 0) ? 1 : int'(on_count);
    need_off = (off_count == 0) ? 1 : int'(off_count);
    hold     = int'(holdoff);
    is_above = (feat_in >= thr_on);
    is_below = (feat_in < thr_off);
    if (m_phase == 3) begin
      if (hold == 0) begin
        m_phase = 0; m_streak = 0;
      end else if (feat_valid) begin
        m_streak++;
        if (m_streak >= hold) begin m_phase = 0; m_streak = 0; end
      end
    end else if (feat_valid) begin
      if (m_phase == 2) begin
        m_streak = is_below ? m_streak + 1 : 0;
        if (m_streak >= need_off) begin
          m_phase = 3; m_streak = 0; m_off = 1;
        end
      end else begin
        m_streak = is_above ? m_streak + 1 : 0;
        m_phase  = is_above ? 1 : 0;
        if (m_streak >= need_on) begin
          m_phase = 2; m_streak = 0; m_on = 1; m_events++;
        end
      end
    end
  endtask

  // Compare process: every cycle after the first reset edge
  always @(negedge clk) begin
    if (armed) begin
      check("state", int'(state), m_phase);
      check("seizure", int'(seizure), int'(m_phase == 2));
      check("onset", int'(onset), int'(m_on));
      check("offset", int'(offset), int'(m_off));
      check("event_count", int'(event_count), (m_events > 65535) ? 65535 : m_events);
      check("event_count_narrow", int'(event_count_s), (m_events > 15) ? 15 : m_events);
      check("state_narrow", int'(state_s), m_phase);
    end
  end

  task automatic step(input logic r, input logic e, input logic v, input int f);
    rst = r; en = e; feat_valid = v; feat_in = 40'(f);
    @(posedge clk);
    model_update();
    armed = 1;
    @(negedge clk);
    #1;
  endtask

  initial begin
    int seq_onset[6]  = '{150, 150, 50, 150, 150, 150};
    int st_onset[6]   = '{1, 1, 0, 1, 1, 2};
    int seq_offset[6] = '{70, 90, 70, 70, 500, 500};
    int st_offset[6]  = '{2, 2, 2, 3, 3, 0};

    thr_on = 40'(100); thr_off = 40'(80);
    on_count = 16'd3; off_count = 16'd2; holdoff = 16'd2;

    // Reset held with feat_valid toggling
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'(i % 2 == 0), 150);
      check("rst_state", int'(state), 0);
      check("rst_seizure", int'(seizure), 0);
    end
    step(1'b0, 1'b1, 1'b0, 0);
    check("rst_release_state", int'(state), 0);

    // Onset qualification
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 1'b1, seq_onset[i]);
      check("onset_seq_state", int'(state), st_onset[i]);
      check("onset_seq_pulse", int'(onset), int'(i == 5));
    end
    check("onset_seq_events", int'(event_count), 1);
    step(1'b0, 1'b1, 1'b0, 0);
    check("onset_pulse_cleared", int'(onset), 0);

    // Offset with streak break, then holdoff ignoring features
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 1'b1, seq_offset[i]);
      check("offset_seq_state", int'(state), st_offset[i]);
      check("offset_seq_pulse", int'(offset), int'(i == 3));
    end

    // Gated valid and enable while qualifying
    step(1'b0, 1'b1, 1'b1, 150);
    check("gate_cand", int'(state), 1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 150);
    step(1'b0, 1'b0, 1'b1, 150);
    check("gate_en_low", int'(state), 1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 150);
    step(1'b0, 1'b1, 1'b1, 150);
    check("gate_second", int'(state), 1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 150);
    step(1'b0, 1'b1, 1'b1, 150);
    check("gate_third_state", int'(state), 2);
    check("gate_third_onset", int'(onset), 1);
    check("gate_events", int'(event_count), 2);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 70);
    check("gate_exit", int'(state), 0);

    // Zero counts, negative-equal threshold
    on_count = '0; off_count = '0; holdoff = '0;
    thr_on = -40'sd5; thr_off = -40'sd5;
    step(1'b0, 1'b1, 1'b1, -5);
    check("edge_onset_state", int'(state), 2);
    check("edge_onset_pulse", int'(onset), 1);
    step(1'b0, 1'b1, 1'b1, -6);
    check("edge_offset_state", int'(state), 3);
    check("edge_offset_pulse", int'(offset), 1);
    step(1'b0, 1'b1, 1'b0, 0);
    check("edge_idle", int'(state), 0);

    // Repeated events: narrow counter saturates, wide one keeps counting
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 1'b1, -5);
      step(1'b0, 1'b1, 1'b1, -6);
      step(1'b0, 1'b1, 1'b0, 0);
    end
    check("sat_narrow", int'(event_count_s), 15);
    check("sat_wide", int'(event_count), 23);

    // Reset mid-event
    step(1'b0, 1'b1, 1'b1, -5);
    check("mid_rst_pre", int'(seizure), 1);
    step(1'b1, 1'b1, 1'b0, 0);
    check("mid_rst_seizure", int'(seizure), 0);
    check("mid_rst_offset", int'(offset), 0);
    check("mid_rst_events", int'(event_count), 0);

    // Randomized traffic with live config changes
    for (int i = 0; i < 4000; i++) begin
      if (i % 40 == 0 || $urandom_range(15) == 0) begin
        thr_on    = 40'(int'($urandom_range(40)) - 20);
        thr_off   = 40'(int'($urandom_range(40)) - 20);
        on_count  = 16'($urandom_range(4));
        off_count = 16'($urandom_range(4));
        holdoff   = 16'($urandom_range(3));
      end
      step(1'($urandom_range(199) == 0), 1'($urandom_range(9) != 0),
           1'($urandom_range(9) < 6), int'($urandom_range(60)) - 30);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
